// File: rtl/equalizer_serial_tx.sv
// Serial audio transmitter: sample FIFO feeding a left-justified two-slot MSB-first frame.
// Optional macro EQ_SERIAL_TX_MONO_DUP_EN repeats the left-slot sample in the right slot.
module equalizer_serial_tx #(
    parameter int unsigned SAMPLE_BITS = 16,
    parameter int unsigned SLOT_BITS   = 32,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clk_enable,
    input  logic signed [SAMPLE_BITS-1:0]   sample_in,
    input  logic                            sample_valid,
    output logic                            sample_ready,
    output logic                            sdata,
    output logic                            ws,
    output logic                            frame_start,
    output logic                            underrun,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

    localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
    localparam int unsigned PAD_BITS   = SLOT_BITS - SAMPLE_BITS;
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W      = PTR_W + 1;
    localparam int unsigned CNT_W      = $clog2(FRAME_BITS);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;

    logic [SAMPLE_BITS-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]        level_q, level_d;

    logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic                    sdata_q, sdata_d;
    logic                    ws_q, ws_d;
    logic                    frame_start_q, frame_start_d;
    logic                    underrun_q, underrun_d;

    logic                    push_c;
    logic                    pop_c;
    logic                    fifo_empty_c;
    logic                    load_c;
    logic [FRAME_BITS-1:0]   load_frame_c;

    // Sample left-justified in its slot; right slot either duplicated or silent.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [SAMPLE_BITS-1:0] s);
        logic [SLOT_BITS-1:0] slot;
        slot = SLOT_BITS'(s) << PAD_BITS;
`ifdef EQ_SERIAL_TX_MONO_DUP_EN
        return {slot, slot};
`else
        return {slot, SLOT_BITS'(0)};
`endif
    endfunction

    assign fifo_empty_c = (level_q == '0);
    assign sample_ready = (level_q != LVL_W'(FIFO_DEPTH));
    assign push_c       = sample_valid && sample_ready;

    // A frame starts on the first enabled edge with data in IDLE, or after the last bit in RUN.
    assign load_c = clk_enable &&
                    (((state_q == IDLE) && !fifo_empty_c) ||
                     ((state_q == RUN) && (bit_cnt_q == CNT_W'(FRAME_BITS - 1))));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (clk_enable && !fifo_empty_c) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shreg_d       = shreg_q;
        sdata_d       = sdata_q;
        ws_d          = ws_q;
        bit_cnt_d     = bit_cnt_q;
        frame_start_d = 1'b0;
        underrun_d    = underrun_q;
        pop_c         = 1'b0;
        load_frame_c  = '0;
        if (load_c) begin
            // Empty at a load can only happen in RUN, so this is the underrun case.
            if (!fifo_empty_c) begin
                pop_c        = 1'b1;
                load_frame_c = build_frame(mem_q[rd_ptr_q]);
            end else begin
                underrun_d   = 1'b1;
            end
            sdata_d       = load_frame_c[FRAME_BITS-1];
            shreg_d       = load_frame_c << 1;
            bit_cnt_d     = '0;
            ws_d          = 1'b0;
            frame_start_d = 1'b1;
        end else if ((state_q == RUN) && clk_enable) begin
            sdata_d   = shreg_q[FRAME_BITS-1];
            shreg_d   = shreg_q << 1;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            ws_d      = (bit_cnt_d >= CNT_W'(SLOT_BITS));
        end
    end

    always_comb begin
        wr_ptr_d = push_c ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop_c  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        level_d  = level_q + LVL_W'(push_c) - LVL_W'(pop_c);
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= sample_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            sdata_q       <= 1'b0;
            ws_q          <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            shreg_q       <= shreg_d;
            bit_cnt_q     <= bit_cnt_d;
            sdata_q       <= sdata_d;
            ws_q          <= ws_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    assign sdata       = sdata_q;
    assign ws          = ws_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;
    assign fifo_level  = level_q;

endmodule

// File: tb/tb_equalizer_serial_tx.sv
// Bench for equalizer_serial_tx: directed stimulus with a sample scoreboard that predicts
// every frame bit, ws, frame_start, underrun, fifo_level and sample_ready each cycle.
module tb_equalizer_serial_tx;

    localparam int SAMPLE_BITS = 16;
    localparam int SLOT_BITS   = 32;
    localparam int FIFO_DEPTH  = 4;
    localparam int FRAME_BITS  = 2 * SLOT_BITS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_enable = 1'b0;
    logic [15:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        sdata;
    logic        ws;
    logic        frame_start;
    logic        underrun;
    logic [2:0]  fifo_level;

    equalizer_serial_tx #(
        .SAMPLE_BITS(SAMPLE_BITS),
        .SLOT_BITS  (SLOT_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clk_enable  (clk_enable),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .sdata       (sdata),
        .ws          (ws),
        .frame_start (frame_start),
        .underrun    (underrun),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] s;
        int          stamp;
    } entry_t;

    entry_t                q[$];
    int                    n_assert = 0;
    int                    n_fail   = 0;
    int                    edge_cnt = 0;
    logic                  last_en  = 1'b0;
    logic                  last_rst = 1'b1;
    logic                  cap_active = 1'b0;
    int                    cur_bit  = 0;
    logic                  exp_ur   = 1'b0;
    logic [FRAME_BITS-1:0] exp_frame = '0;
    logic                  exp_fs;
    logic                  eligible;
    entry_t                ent;
    int                    fs_first;
    int                    fs_second;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [15:0] s);
        logic [31:0] slot;
        slot = {s, 16'h0000};
`ifdef EQ_SERIAL_TX_MONO_DUP_EN
        return {slot, slot};
`else
        return {slot, 32'h0};
`endif
    endfunction

    // Input side of the scoreboard: record accepted samples with the edge they entered on.
    always @(posedge clk) begin
        edge_cnt++;
        last_en  = clk_enable;
        last_rst = rst;
        if (rst) begin
            q.delete();
            exp_ur     = 1'b0;
            cap_active = 1'b0;
            cur_bit    = 0;
        end else if (sample_valid && (q.size() < FIFO_DEPTH)) begin
            ent.s     = sample_in;
            ent.stamp = edge_cnt;
            q.push_back(ent);
        end
    end

    // Output side: advance the expected frame on enabled edges and compare every cycle.
    always @(negedge clk) begin
        exp_fs = 1'b0;
        if (!last_rst && last_en) begin
            eligible = (q.size() > 0) && (q[0].stamp < edge_cnt);
            if (cap_active) begin
                if (cur_bit == FRAME_BITS - 1) begin
                    exp_fs  = 1'b1;
                    cur_bit = 0;
                    if (eligible) begin
                        ent       = q.pop_front();
                        exp_frame = make_frame(ent.s);
                    end else begin
                        exp_frame = '0;
                        exp_ur    = 1'b1;
                    end
                end else begin
                    cur_bit++;
                end
            end else if (eligible) begin
                ent        = q.pop_front();
                exp_frame  = make_frame(ent.s);
                exp_fs     = 1'b1;
                cur_bit    = 0;
                cap_active = 1'b1;
            end
        end
        check("frame_start", 64'(frame_start), 64'(exp_fs));
        check("underrun", 64'(underrun), 64'(exp_ur));
        check("fifo_level", 64'(fifo_level), 64'(q.size()));
        check("sample_ready", 64'(sample_ready), 64'(q.size() < FIFO_DEPTH));
        if (cap_active) begin
            check("sdata", 64'(sdata), 64'(exp_frame[FRAME_BITS-1-cur_bit]));
            check("ws", 64'(ws), 64'(cur_bit >= SLOT_BITS));
        end else begin
            check("sdata_idle", 64'(sdata), 64'(0));
            check("ws_idle", 64'(ws), 64'(0));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_one(input logic [15:0] s);
        sample_in    = s;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        clk_enable   = 1'b1;
        sample_valid = 1'b0;
        cycles(2);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state, then a single sample followed by an underrun frame
        do_reset();
        #1;
        check("rst_sdata", 64'(sdata), 64'(0));
        check("rst_ws", 64'(ws), 64'(0));
        check("rst_frame_start", 64'(frame_start), 64'(0));
        check("rst_underrun", 64'(underrun), 64'(0));
        check("rst_level", 64'(fifo_level), 64'(0));
        check("rst_ready", 64'(sample_ready), 64'(1));
        push_one(16'h8001);
        cycles(140);
        #1;
        check("underrun_sticky", 64'(underrun), 64'(1));

        // Backpressure with the bit engine stalled
        do_reset();
        clk_enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample_in    = 16'h1111 * 16'(i + 1);
            sample_valid = 1'b1;
            @(negedge clk);
        end
        #1;
        check("bp_level", 64'(fifo_level), 64'(4));
        check("bp_ready", 64'(sample_ready), 64'(0));
        clk_enable = 1'b1;
        cycles(2);
        sample_valid = 1'b0;
        cycles(400);

        // Gated enable: one bit per two clocks
        do_reset();
        clk_enable   = 1'b0;
        sample_in    = 16'h7FFF;
        sample_valid = 1'b1;
        fs_first     = -1;
        fs_second    = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            sample_valid = 1'b0;
            clk_enable   = ~clk_enable;
            #1;
            if (frame_start) begin
                if (fs_first < 0) fs_first = i;
                else if (fs_second < 0) fs_second = i;
            end
        end
        check("gated_period", 64'(fs_second - fs_first), 64'(128));

        // Push at the frame boundary with level 1, then with the FIFO empty
        do_reset();
        push_one(16'hA5A5);
        cycles(9);
        push_one(16'h1234);
        cycles(54);
        push_one(16'hC3C3);
        #1;
        check("sim_level", 64'(fifo_level), 64'(1));
        check("sim_no_underrun", 64'(underrun), 64'(0));
        cycles(127);
        push_one(16'h0F0F);
        #1;
        check("sim_empty_underrun", 64'(underrun), 64'(1));
        check("sim_empty_level", 64'(fifo_level), 64'(1));
        cycles(140);

        // Reset in the middle of a frame with two samples queued
        do_reset();
        push_one(16'h5555);
        push_one(16'h6666);
        push_one(16'h7777);
        cycles(19);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_sdata", 64'(sdata), 64'(0));
        check("mid_rst_ws", 64'(ws), 64'(0));
        check("mid_rst_level", 64'(fifo_level), 64'(0));
        check("mid_rst_underrun", 64'(underrun), 64'(0));
        push_one(16'h9ABC);
        #1;
        check("restart_frame_start", 64'(frame_start), 64'(0));
        @(negedge clk);
        #1;
        check("restart_msb", 64'(sdata), 64'(1));
        check("restart_fs", 64'(frame_start), 64'(1));
        cycles(70);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
